// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the MEM-stage access controller: a request/ack handshake
// carrying a word address, write data and returned read data.
interface mem_access_ctrl_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one memory request per access,
// stalls the pipeline until ack/timeout/misalignment, then releases it for one cycle.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              err_o,
    mem_access_ctrl_if.master mem_bus
);

    localparam int CNT_BITS_NEEDED = $clog2(TIMEOUT_CYCLES + 32'sd1);
    localparam int CNT_W           = (CNT_BITS_NEEDED > 32'sd4) ? CNT_BITS_NEEDED : 32'sd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              req_r, req_s;
    logic              we_r, we_s;
    logic              err_r, err_s;
    logic [31:0]       addr_r, addr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [31:0]       rdata_r, rdata_s;
    logic              access_s;
    logic              aligned_s;
    logic              stall_s;

    assign access_s  = MemRead_i | MemWrite_i;
    assign aligned_s = (addr_i[1:0] == 2'b00);

    // Pipeline freeze: held while an access waits in IDLE or is outstanding in REQ.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = access_s;
            REQ:     stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Next-state and next-register values; everything holds unless a branch overrides it.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        req_s   = req_r;
        we_s    = we_r;
        err_s   = err_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                err_s = 1'b0;
                if (access_s && aligned_s) begin
                    state_s = REQ;
                    req_s   = 1'b1;
                    we_s    = MemWrite_i;
                    addr_s  = addr_i;
                    wdata_s = wdata_i;
                    cnt_s   = CNT_ZERO;
                end else if (access_s) begin
                    state_s = DONE;
                    err_s   = 1'b1;
                    rdata_s = 32'h0000_0000;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // An ack arriving on the final counted cycle still completes cleanly.
                if (mem_bus.mem_ack_i) begin
                    state_s = DONE;
                    req_s   = 1'b0;
                    err_s   = 1'b0;
                    if (!we_r) begin
                        rdata_s = mem_bus.mem_rdata_i;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                    req_s   = 1'b0;
                    err_s   = 1'b1;
                    rdata_s = 32'h0000_0000;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
                err_s   = 1'b0;
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
                err_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            we_r    <= we_s;
            err_r   <= err_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
        end
    end

    assign stall_o             = stall_s;
    assign err_o               = err_r;
    assign rdata_o             = rdata_r;
    assign mem_bus.mem_req_o   = req_r;
    assign mem_bus.mem_we_o    = we_r;
    assign mem_bus.mem_addr_o  = addr_r;
    assign mem_bus.mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl; the bench acts as the memory
// and predicts stall count, request length, error and load data per access.
module tb_mem_access_ctrl;

    localparam int T = 15;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_rdata;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (mem_read),
        .MemWrite_i (mem_write),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .err_o      (err),
        .mem_bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One cycle with no access; an optional stray ack must change nothing.
    task automatic idle_cycle(input logic ack_noise);
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        bus.mem_ack_i    = ack_noise;
        bus.mem_rdata_i  = $urandom;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_req",   {31'd0, bus.mem_req_o}, 32'd0);
        chk("idle_err",   {31'd0, err}, 32'd0);
        chk("idle_rdata", rdata, model_rdata);
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
    endtask

    // Present one access and act as memory, acking on request cycle k (k >= T means never).
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rmem, input int k);
        int          stalls;
        int          reqs;
        int          cyc;
        bit          done;
        int          exp_stalls;
        int          exp_reqs;
        logic        exp_err;
        logic [31:0] exp_rdata;

        if (a[1:0] != 2'b00) begin
            exp_stalls = 1;     exp_reqs = 0;   exp_err = 1'b1; exp_rdata = 32'd0;
        end else if (k < T) begin
            exp_stalls = k + 2; exp_reqs = k + 1; exp_err = 1'b0;
            exp_rdata  = wr ? model_rdata : rmem;
        end else begin
            exp_stalls = T + 1; exp_reqs = T;   exp_err = 1'b1; exp_rdata = 32'd0;
        end

        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        stalls    = 0;
        reqs      = 0;
        cyc       = 0;
        done      = 1'b0;
        while (!done && cyc < 4 * T) begin
            if (bus.mem_req_o) begin
                bus.mem_ack_i   = (reqs == k);
                bus.mem_rdata_i = (reqs == k) ? rmem : $urandom;
                reqs++;
                chk({name, "_addr"},  bus.mem_addr_o, a);
                chk({name, "_wdata"}, bus.mem_wdata_o, wd);
                chk({name, "_we"},    {31'd0, bus.mem_we_o}, {31'd0, wr});
            end else begin
                bus.mem_ack_i   = ($urandom_range(3, 0) == 0);
                bus.mem_rdata_i = $urandom;
            end
            #1;
            if (stall) begin
                stalls++;
                chk({name, "_err_busy"}, {31'd0, err}, 32'd0);
            end else begin
                done = 1'b1;
                chk({name, "_err"},      {31'd0, err}, {31'd0, exp_err});
                chk({name, "_rdata"},    rdata, exp_rdata);
                chk({name, "_req_done"}, {31'd0, bus.mem_req_o}, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack_i = 1'b0;
        chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({name, "_stalls"},    stalls, exp_stalls);
        chk({name, "_req_cycles"}, reqs, exp_reqs);
        model_rdata = exp_rdata;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          sel;

        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        addr            = 32'd0;
        wdata           = 32'd0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'd0;
        model_rdata     = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req",   {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_we",    {31'd0, bus.mem_we_o}, 32'd0);
        chk("rst_addr",  bus.mem_addr_o, 32'd0);
        chk("rst_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);

        run_access("rd40",   1'b1, 1'b0, 32'h0000_0040, 32'h1111_1111, 32'hDEAD_BEEF, 3);
        run_access("wr80",   1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'h5555_AAAA, 0);
        run_access("rd42",   1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h7777_7777, 0);
        run_access("tmo",    1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h8888_8888, 99);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        run_access("b2b10",  1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_0010, 2);
        run_access("b2b14",  1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'h5A5A_0014, 1);
        run_access("rdwr",   1'b1, 1'b1, 32'h0000_0200, 32'hFEED_0001, 32'h0BAD_0BAD, 1);
        run_access("last",   1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hC0DE_0300, T - 1);
        run_access("edge",   1'b1, 1'b0, 32'h0000_0304, 32'h0, 32'hC0DE_0304, T);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(2, 0);
            r   = $urandom;
            a   = {r[31:2], 2'b00};
            if ($urandom_range(3, 0) == 0) a[1:0] = 2'($urandom_range(3, 1));
            run_access("rnd", (sel != 1), (sel != 0), a, $urandom, $urandom,
                       int'($urandom_range(T + 2, 0)));
            if ($urandom_range(1, 0) == 1) idle_cycle(1'($urandom_range(1, 0)));
        end

        // Reset on the second REQ cycle, together with an ack: reset must win.
        mem_read  = 1'b1;
        mem_write = 1'b0;
        addr      = 32'h0000_0020;
        @(negedge clk);
        chk("mid_req_up", {31'd0, bus.mem_req_o}, 32'd1);
        @(negedge clk);
        rst             = 1'b1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        rst           = 1'b0;
        mem_read      = 1'b0;
        bus.mem_ack_i = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, bus.mem_req_o}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_err",   {31'd0, err}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_addr",  bus.mem_addr_o, 32'd0);
        model_rdata = 32'd0;
        @(negedge clk);
        idle_cycle(1'b0);
        run_access("post_rst", 1'b1, 1'b0, 32'h0000_0024, 32'h0, 32'h2468_ACE0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
